dmem_sized_port: RTL and testbench
==================================

// Module: dmem_sized_port
// PURPOSE
//  Byte-addressed, little-endian data memory for the CPU load/store stage, generalised in depth and access
//  latency. Supports byte, half-word and word access with sign or zero extension, alignment/range checking,
//  and a req/ready/valid handshake with a fixed, parametrised number of wait states.
//  Sits between the MEM-stage control logic and the backing byte array; the pipeline stalls on ready_o/valid_o.
// PARAMETERS
//  ADDR_W       32    address width in bits
//  DEPTH_BYTES  1024  memory size in bytes; must be a multiple of 4
//  LATENCY      2     wait cycles between acceptance and response, range 0..15
// PORTS
//  clk_i        in   1       clock; all state changes on the rising edge
//  rst_n_i      in   1       asynchronous active-low reset
//  req_i        in   1       request valid
//  we_i         in   1       1 = store, 0 = load
//  size_i       in   2       00 byte, 01 half, 10 word, 11 illegal
//  unsigned_i   in   1       loads only: 1 = zero-extend, 0 = sign-extend
//  addr_i       in   ADDR_W  byte address
//  data_i       in   32      store data, right-aligned (byte in [7:0], half in [15:0])
//  ready_o      out  1       block accepts a request this cycle
//  valid_o      out  1       one-cycle response strobe
//  data_o       out  32      load result, extended to 32 bits; 0 for stores and errors
//  err_o        out  1       qualifies valid_o: access was misaligned, out of range or of illegal size
// BEHAVIOUR
//  Reset (async, rst_n_i=0): state IDLE, wait counter 0, ready_o=1, valid_o=0, data_o=0, err_o=0.
//   The memory array is not cleared; contents are undefined until written.
//  FSM states: IDLE -> WAIT -> RESP -> IDLE.
//   IDLE: ready_o=1. When req_i&&ready_o is high at an edge, capture we/size/unsigned/addr/data and run the
//    error check. Go to WAIT with counter=LATENCY; if LATENCY=0, go directly to RESP.
//   WAIT: ready_o=0. Decrement the counter each edge. On the edge where the counter reaches 0, go to RESP.
//   RESP: ready_o=0, valid_o=1 for exactly one cycle. Always return to IDLE on the next edge.
//  Latency: acceptance at edge N gives valid_o high in the cycle after edge N+LATENCY.
//   Peak throughput is one request per LATENCY+2 cycles.
//  Memory side effects: the store write and the load read both happen on the edge entering RESP.
//   data_o and err_o are registered on that same edge.
//  Error check, in the captured request:
//   - size 11;
//   - half-word access with addr[0]!=0;
//   - word access with addr[1:0]!=0;
//   - addr + access bytes > DEPTH_BYTES.
//   On error there is no memory access; the response keeps the normal latency with err_o=1 and data_o=0.
//  Store: write 1/2/4 bytes little-endian from data_i[7:0] upward at addr; other bytes are untouched.
//  Load: byte mem[a]; half {mem[a+1],mem[a]}; word {mem[a+3]..mem[a]}. The result is extended to 32 bits
//   per unsigned_i.
//  Store response: data_o=0, err_o=0.
//  req_i while ready_o=0 is ignored, not queued; the requester must hold req_i until it sees ready_o.
//  Inputs are sampled only at acceptance; changes afterwards do not affect an in-flight access.
//  Reset mid-operation (WAIT or RESP): the access is aborted with no valid_o and no memory write.
//   Reset takes effect immediately.
//  data_o and err_o hold their value outside RESP until the next response.
// TESTING
//  (LATENCY=2)
//  1. Store word 0xDEADBEEF at 0x10 accepted at edge N -> valid_o only in the cycle after edge N+2,
//     err_o=0, data_o=0; ready_o low for 3 cycles.
//  2. Load word 0x10 -> 0xDEADBEEF. Load byte 0x13 signed -> 0xFFFFFFDE, unsigned -> 0x000000DE.
//     Load half 0x12 signed -> 0xFFFFDEAD.
//  3. Store byte 0x55 at 0x11, then load word 0x10 -> 0xDEAD55EF; neighbouring bytes unchanged.
//  4. Half store at 0x11, word load at 0x12, size 11, word load at DEPTH_BYTES-2 -> each gives
//     err_o=1, data_o=0 with normal latency; a later word load at 0x10 still returns 0xDEAD55EF.
//  5. Assert rst_n_i low during WAIT of a word store 0x12345678 to 0x20 -> outputs go to reset values at once;
//     no valid_o follows; load of 0x20 after reset returns the earlier content of 0x20.
//  6. Pulse req_i with a store during WAIT/RESP -> ignored, no extra valid_o, memory unchanged.
//     Repeat tests 1-2 with LATENCY=0 -> valid_o in the cycle right after acceptance.

Source files
------------

// File: rtl/dmem_sized_port_if.sv
// rtl/dmem_sized_port_if.sv - request/response bus between the MEM stage and the data memory
// Purpose: bundles the load/store handshake of dmem_sized_port.
// Signals: req_i/we_i/size_i/unsigned_i/addr_i/data_i driven by the requester;
//          ready_o/valid_o/data_o/err_o driven by the memory.
interface dmem_sized_port_if #(
    parameter int ADDR_W = 32
);
    logic              req_i;
    logic              we_i;
    logic [1:0]        size_i;
    logic              unsigned_i;
    logic [ADDR_W-1:0] addr_i;
    logic [31:0]       data_i;
    logic              ready_o;
    logic              valid_o;
    logic [31:0]       data_o;
    logic              err_o;

    modport master (
        output req_i, we_i, size_i, unsigned_i, addr_i, data_i,
        input  ready_o, valid_o, data_o, err_o
    );

    modport slave (
        input  req_i, we_i, size_i, unsigned_i, addr_i, data_i,
        output ready_o, valid_o, data_o, err_o
    );
endinterface

// File: rtl/dmem_sized_port.sv
// rtl/dmem_sized_port.sv - byte-addressed little-endian data memory with fixed wait states
// Purpose: byte/half/word loads and stores with sign/zero extension, alignment and range
//          checking, and a req/ready/valid handshake with LATENCY wait cycles.
// Ports: clk_i   - clock, rising edge
//        rst_n_i - asynchronous active-low reset
//        bus     - slave side of dmem_sized_port_if (request fields in, ready/valid/data/err out)
module dmem_sized_port #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 2
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    dmem_sized_port_if.slave bus
);
    localparam int IW = $clog2(DEPTH_BYTES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;

    logic              cap_we;
    logic [1:0]        cap_size;
    logic              cap_uns;
    logic [ADDR_W-1:0] cap_addr;
    logic [31:0]       cap_data;

    logic [31:0]       data_q;
    logic              err_q;

    logic [7:0]        mem [DEPTH_BYTES];

    logic              accept;
    logic              do_access;

    // With LATENCY=0 the access happens on the accepting edge itself, so the
    // live request fields are used in IDLE and the captured copy otherwise.
    logic              op_we;
    logic [1:0]        op_size;
    logic              op_uns;
    logic [ADDR_W-1:0] op_addr;
    logic [31:0]       op_data;
    logic              op_err;
    logic [2:0]        nbytes;
    logic [ADDR_W:0]   end_addr;
    logic [IW-1:0]     idx;
    logic [7:0]        b0, b1, b2, b3;
    logic [31:0]       load_val;

    assign accept = bus.req_i && (state == IDLE);

    assign op_we   = (state == IDLE) ? bus.we_i       : cap_we;
    assign op_size = (state == IDLE) ? bus.size_i     : cap_size;
    assign op_uns  = (state == IDLE) ? bus.unsigned_i : cap_uns;
    assign op_addr = (state == IDLE) ? bus.addr_i     : cap_addr;
    assign op_data = (state == IDLE) ? bus.data_i     : cap_data;

    always_comb begin
        nbytes = 3'd4;
        case (op_size)
            2'b00:   nbytes = 3'd1;
            2'b01:   nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
    end

    // One extra bit so an access near the top of the address space cannot wrap.
    assign end_addr = {1'b0, op_addr} + (ADDR_W+1)'(nbytes);

    assign op_err = (op_size == 2'b11)
                 || (op_size == 2'b01 && op_addr[0])
                 || (op_size == 2'b10 && op_addr[1:0] != 2'b00)
                 || (end_addr > (ADDR_W+1)'(DEPTH_BYTES));

    assign idx = op_addr[IW-1:0];
    assign b0  = mem[idx];
    assign b1  = mem[idx + IW'(1)];
    assign b2  = mem[idx + IW'(2)];
    assign b3  = mem[idx + IW'(3)];

    always_comb begin
        load_val = {b3, b2, b1, b0};
        case (op_size)
            2'b00:   load_val = op_uns ? {24'd0, b0} : {{24{b0[7]}}, b0};
            2'b01:   load_val = op_uns ? {16'd0, b1, b0} : {{16{b1[7]}}, b1, b0};
            default: load_val = {b3, b2, b1, b0};
        endcase
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_nx = RESP;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = 4'(LATENCY);
                    end
                end
            end
            WAIT: begin
                cnt_nx = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_nx = RESP;
                    cnt_nx   = 4'd0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // The memory is touched only on the edge that enters RESP.
    assign do_access = (state_nx == RESP) && (state != RESP);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            cap_we   <= 1'b0;
            cap_size <= 2'b00;
            cap_uns  <= 1'b0;
            cap_addr <= '0;
            cap_data <= 32'd0;
            data_q   <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                cap_we   <= bus.we_i;
                cap_size <= bus.size_i;
                cap_uns  <= bus.unsigned_i;
                cap_addr <= bus.addr_i;
                cap_data <= bus.data_i;
            end
            if (do_access) begin
                data_q <= (op_err || op_we) ? 32'd0 : load_val;
                err_q  <= op_err;
            end
        end
    end

    // The array has no reset; rst_n_i gates the write so a reset edge never stores.
    always_ff @(posedge clk_i) begin
        if (rst_n_i && do_access && op_we && !op_err) begin
            mem[idx] <= op_data[7:0];
            if (op_size != 2'b00) begin
                mem[idx + IW'(1)] <= op_data[15:8];
            end
            if (op_size == 2'b10) begin
                mem[idx + IW'(2)] <= op_data[23:16];
                mem[idx + IW'(3)] <= op_data[31:24];
            end
        end
    end

    assign bus.ready_o = (state == IDLE);
    assign bus.valid_o = (state == RESP);
    assign bus.data_o  = data_q;
    assign bus.err_o   = err_q;
endmodule

// File: tb/tb_dmem_sized_port.sv
// tb/tb_dmem_sized_port.sv - scoreboard bench for dmem_sized_port at LATENCY 2 and 0
module tb_dmem_sized_port;
    logic clk;
    logic rst_n;
    int   cyc;
    int   n_chk;
    int   n_fail;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          c;
    } exp_t;

    exp_t q2[$];
    exp_t q0[$];

    dmem_sized_port_if #(.ADDR_W(32)) bus2 ();
    dmem_sized_port_if #(.ADDR_W(32)) bus0 ();

    dmem_sized_port #(.ADDR_W(32), .DEPTH_BYTES(1024), .LATENCY(2)) u_dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus2)
    );

    dmem_sized_port #(.ADDR_W(32), .DEPTH_BYTES(1024), .LATENCY(0)) u_dut0 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus2.valid_o) begin
            chk("l2_valid_expected", 64'(q2.size() != 0), 64'd1);
            if (q2.size() != 0) begin
                e = q2.pop_front();
                chk("l2_data", 64'(bus2.data_o), 64'(e.d));
                chk("l2_err", 64'(bus2.err_o), 64'(e.e));
                chk("l2_latency", 64'(cyc), 64'(e.c));
            end
        end
        if (bus0.valid_o) begin
            chk("l0_valid_expected", 64'(q0.size() != 0), 64'd1);
            if (q0.size() != 0) begin
                e = q0.pop_front();
                chk("l0_data", 64'(bus0.data_o), 64'(e.d));
                chk("l0_err", 64'(bus0.err_o), 64'(e.e));
                chk("l0_latency", 64'(cyc), 64'(e.c));
            end
        end
    end

    function automatic logic rdy(input int sel);
        return (sel != 0) ? bus0.ready_o : bus2.ready_o;
    endfunction

    task automatic set_fields(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] data);
        bus2.we_i = we;   bus0.we_i = we;
        bus2.size_i = size; bus0.size_i = size;
        bus2.unsigned_i = uns; bus0.unsigned_i = uns;
        bus2.addr_i = addr; bus0.addr_i = addr;
        bus2.data_i = data; bus0.data_i = data;
    endtask

    // sel 0 drives the LATENCY=2 instance, sel 1 the LATENCY=0 instance.
    task automatic issue(input int sel, input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] ed, input logic ee);
        int   n;
        int   lat;
        exp_t e;
        lat = (sel != 0) ? 0 : 2;
        @(negedge clk);
        n = 0;
        while (!rdy(sel) && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("ready_timeout", 64'(n < 100), 64'd1);
        set_fields(we, size, uns, addr, data);
        if (sel != 0) bus0.req_i = 1'b1;
        else          bus2.req_i = 1'b1;
        e.d = ed;
        e.e = ee;
        e.c = cyc + 1 + lat;
        if (sel != 0) q0.push_back(e);
        else          q2.push_back(e);
        @(posedge clk);
        #1;
        bus2.req_i = 1'b0;
        bus0.req_i = 1'b0;
        set_fields(~we, 2'($urandom_range(3)), ~uns, $urandom, $urandom);
        n = 0;
        @(negedge clk);
        while (!rdy(sel) && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", 64'(n), 64'(lat + 1));
        chk("resp_seen", 64'((sel != 0) ? q0.size() : q2.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        cyc    = 0;
        rst_n  = 1'b0;
        bus2.req_i = 1'b0;
        bus0.req_i = 1'b0;
        set_fields(1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(bus2.ready_o), 64'd1);
        chk("rst_valid", 64'(bus2.valid_o), 64'd0);
        chk("rst_data", 64'(bus2.data_o), 64'd0);
        chk("rst_err", 64'(bus2.err_o), 64'd0);
        chk("rst0_ready", 64'(bus0.ready_o), 64'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Store, then loads of every width and extension
        issue(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        issue(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        issue(0, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
        issue(0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h000000DE, 1'b0);
        issue(0, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0);
        issue(0, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h0000DEAD, 1'b0);
        issue(0, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0);
        issue(0, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0);

        // Byte store leaves neighbours intact
        issue(0, 1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFF55, 32'h0, 1'b0);
        issue(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0);

        // Error cases keep normal latency and do not touch memory
        issue(0, 1'b1, 2'b01, 1'b0, 32'h11, 32'h0000AAAA, 32'h0, 1'b1);
        issue(0, 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1);
        issue(0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1);
        issue(0, 1'b0, 2'b10, 1'b0, 32'd1022, 32'h0, 32'h0, 1'b1);
        issue(0, 1'b0, 2'b00, 1'b0, 32'd1024, 32'h0, 32'h0, 1'b1);
        issue(0, 1'b1, 2'b10, 1'b0, 32'h8000_0010, 32'h01020304, 32'h0, 1'b1);
        issue(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0);

        // Top-of-memory word is in range
        issue(0, 1'b1, 2'b10, 1'b0, 32'd1020, 32'h11223344, 32'h0, 1'b0);
        issue(0, 1'b0, 2'b10, 1'b0, 32'd1020, 32'h0, 32'h11223344, 1'b0);
        issue(0, 1'b0, 2'b00, 1'b1, 32'd1023, 32'h0, 32'h00000011, 1'b0);
        issue(0, 1'b0, 2'b01, 1'b0, 32'd1022, 32'h0, 32'h00001122, 1'b0);

        // Reset during WAIT aborts a store
        issue(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0);
        issue(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0);
        @(negedge clk);
        set_fields(1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678);
        bus2.req_i = 1'b1;
        @(posedge clk);
        #1;
        bus2.req_i = 1'b0;
        @(negedge clk);
        chk("mid_wait_busy", 64'(bus2.ready_o), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", 64'(bus2.ready_o), 64'd1);
        chk("abort_valid", 64'(bus2.valid_o), 64'd0);
        chk("abort_data", 64'(bus2.data_o), 64'd0);
        chk("abort_err", 64'(bus2.err_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("abort_no_resp", 64'(q2.size()), 64'd0);
        issue(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);

        // A store pulsed while busy is ignored
        issue(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0);
        @(negedge clk);
        set_fields(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        bus2.req_i = 1'b1;
        q2.push_back('{d: 32'hDEAD55EF, e: 1'b0, c: cyc + 3});
        @(posedge clk);
        #1;
        set_fields(1'b1, 2'b10, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("pulse_in_resp", 64'(bus2.valid_o), 64'd1);
        bus2.req_i = 1'b0;
        repeat (4) @(negedge clk);
        chk("pulse_no_extra", 64'(q2.size()), 64'd0);
        chk("pulse_idle", 64'(bus2.ready_o), 64'd1);
        issue(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0);

        // Zero-latency instance
        issue(1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        issue(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        issue(1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
        issue(1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h000000DE, 1'b0);
        issue(1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0);
        issue(1, 1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1);

        repeat (3) @(negedge clk);
        chk("final_q2_empty", 64'(q2.size()), 64'd0);
        chk("final_q0_empty", 64'(q0.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
